// File: rtl/lock_bank_if.sv
// Unlock request/response handshake between the configuration bus front-end
// (master) and lock_bank_ctrl (slave).
interface lock_bank_if #(
  parameter int NUM_LOCKS = 4,
  parameter int KEY_W     = 32
);
  localparam int IDX_W = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;

  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] req_idx;
  logic [KEY_W-1:0] req_key;
  logic             resp_valid;
  logic             resp_ok;

  modport master (
    output req_valid,
    output req_idx,
    output req_key,
    input  req_ready,
    input  resp_valid,
    input  resp_ok
  );

  modport slave (
    input  req_valid,
    input  req_idx,
    input  req_key,
    output req_ready,
    output resp_valid,
    output resp_ok
  );
endinterface

// File: rtl/lock_bank_ctrl.sv
// Bank of power-on lock bits released by keyed unlock requests; MAX_FAIL consecutive
// bad keys force a lockout until reset. Define LOCK_TIMEOUT_EN for per-channel auto-relock.
module lock_bank_ctrl #(
  parameter int          NUM_LOCKS     = 4,
  parameter int          KEY_W         = 32,
  parameter logic [31:0] UNLOCK_KEY    = 32'hA5C3_0F1E,
  parameter int          MAX_FAIL      = 3,
  parameter int          RELOCK_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             resetn,
  lock_bank_if.slave                       bus,
  input  logic [NUM_LOCKS-1:0]             relock,
  output logic [NUM_LOCKS-1:0]             locked,
  output logic                             lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt
);

  localparam int IDX_W  = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  localparam logic [KEY_W-1:0]  KEY_L   = KEY_W'(UNLOCK_KEY);
  localparam logic [IDX_W:0]    NLOCK_L = (IDX_W + 1)'(NUM_LOCKS);
  localparam logic [FAIL_W-1:0] MAXF_L  = FAIL_W'(MAX_FAIL);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_RESP    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic                 ready_q, ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_ok_q, resp_ok_d;
  logic                 lockout_q, lockout_d;
  logic [FAIL_W-1:0]    fail_q, fail_d;
  logic [FAIL_W-1:0]    fail_inc_s;
  logic [NUM_LOCKS-1:0] locked_q, locked_d;
  logic                 pass_s;
  logic [NUM_LOCKS-1:0] unlock_s;
  logic [NUM_LOCKS-1:0] expire_s;

  // Decode the captured request: pass flag, channel to release, saturated fail count
  always_comb begin
    pass_s   = (state_q == ST_CHECK) && (key_q == KEY_L) && ({1'b0, idx_q} < NLOCK_L);
    unlock_s = {NUM_LOCKS{1'b0}};
    for (int i = 0; i < NUM_LOCKS; i++) begin
      unlock_s[i] = pass_s && (idx_q == IDX_W'(i));
    end
    if (fail_q == MAXF_L) begin
      fail_inc_s = MAXF_L;
    end else begin
      fail_inc_s = fail_q + FAIL_W'(1);
    end
  end

`ifdef LOCK_TIMEOUT_EN
  localparam int               CNT_W = $clog2(RELOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] EXP_L = CNT_W'(RELOCK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [NUM_LOCKS];
  logic [CNT_W-1:0] cnt_d [NUM_LOCKS];

  // Relock timers: held at zero while locked, restarted by a passing unlock
  always_comb begin
    expire_s = {NUM_LOCKS{1'b0}};
    for (int i = 0; i < NUM_LOCKS; i++) begin
      if (locked_q[i] || unlock_s[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else begin
        cnt_d[i]    = cnt_q[i] + CNT_W'(1);
        expire_s[i] = (cnt_q[i] == EXP_L);
      end
    end
  end

  // Relock timer registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_LOCKS; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_LOCKS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  logic unused_relock_cfg_s;
  assign expire_s            = {NUM_LOCKS{1'b0}};
  assign unused_relock_cfg_s = (RELOCK_CYCLES > 0);
`endif

  // Next-state and registered-output logic of the unlock FSM
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    key_d        = key_q;
    resp_valid_d = 1'b0;
    resp_ok_d    = resp_ok_q;
    lockout_d    = lockout_q;
    fail_d       = fail_q;
    // A same-edge relock beats the unlock; a passing unlock beats its own timer expiry
    locked_d     = ((locked_q | expire_s) & ~unlock_s) | relock;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && ready_q) begin
          idx_d   = bus.req_idx;
          key_d   = bus.req_key;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        resp_valid_d = 1'b1;
        if (pass_s) begin
          fail_d    = {FAIL_W{1'b0}};
          resp_ok_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          fail_d    = fail_inc_s;
          resp_ok_d = 1'b0;
          if (fail_inc_s == MAXF_L) begin
            state_d   = ST_LOCKOUT;
            lockout_d = 1'b1;
            locked_d  = {NUM_LOCKS{1'b1}};
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        lockout_d = 1'b1;
        locked_d  = {NUM_LOCKS{1'b1}};
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; every lock bit powers up set
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      idx_q        <= {IDX_W{1'b0}};
      key_q        <= {KEY_W{1'b0}};
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      lockout_q    <= 1'b0;
      fail_q       <= {FAIL_W{1'b0}};
      locked_q     <= {NUM_LOCKS{1'b1}};
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      key_q        <= key_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_ok_q    <= resp_ok_d;
      lockout_q    <= lockout_d;
      fail_q       <= fail_d;
      locked_q     <= locked_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_ok    = resp_ok_q;
  assign locked         = locked_q;
  assign lockout        = lockout_q;
  assign fail_cnt       = fail_q;

endmodule

// File: tb/tb_lock_bank_ctrl.sv
// Self-checking bench for lock_bank_ctrl: directed scenarios plus random requests
// compared against a transaction-level model of the lock bank.
module tb_lock_bank_ctrl;
  localparam int          NL     = 4;
  localparam int          KW     = 32;
  localparam logic [31:0] KEY    = 32'hA5C3_0F1E;
  localparam int          MAXF   = 3;
  localparam int          RELOCK = 8;
`ifdef LOCK_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic [NL-1:0] relock;
  logic [NL-1:0] locked;
  logic          lockout;
  logic [1:0]    fail_cnt;

  lock_bank_if #(.NUM_LOCKS(NL), .KEY_W(KW)) bus ();

  lock_bank_ctrl #(
    .NUM_LOCKS(NL), .KEY_W(KW), .UNLOCK_KEY(KEY), .MAX_FAIL(MAXF), .RELOCK_CYCLES(RELOCK)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .relock(relock),
    .locked(locked), .lockout(lockout), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: lock bits, cycle of last unlock, consecutive failures, lockout flag
  bit m_locked [NL];
  int m_ucyc   [NL];
  int m_fail;
  bit m_lockout;
  int checks = 0;
  int errors = 0;

  function automatic logic [NL-1:0] eff_locked(input int n);
    logic [NL-1:0] v;
    for (int i = 0; i < NL; i++) v[i] = m_locked[i] || (TMO && ((n - m_ucyc[i]) >= RELOCK));
    return v;
  endfunction

  task automatic store(input logic [NL-1:0] v);
    for (int i = 0; i < NL; i++) m_locked[i] = v[i];
  endtask

  task automatic m_reset();
    for (int i = 0; i < NL; i++) begin m_locked[i] = 1'b1; m_ucyc[i] = 0; end
    m_fail = 0; m_lockout = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_locked"}, 32'(locked), 32'(eff_locked(cyc)));
    chk({tag, "_lockout"}, 32'(lockout), 32'(m_lockout));
    chk({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(m_fail));
  endtask

  task automatic idle(input logic [NL-1:0] rl);
    logic [NL-1:0] v;
    relock = rl;
    @(posedge clk); #1;
    relock = '0;
    v = eff_locked(cyc);
    if (!m_lockout) v = v | rl;
    store(v);
    @(negedge clk);
    chk_all("idle");
  endtask

  // One full request: handshake, CHECK cycle with relock rl, response, return to IDLE
  task automatic do_req(input logic [1:0] idx, input logic [31:0] key, input logic [NL-1:0] rl);
    int            n;
    bit            pass;
    logic [NL-1:0] v;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("ready_wait", 32'(bus.req_ready), 32'd1);
    if (bus.req_ready !== 1'b1) return;
    bus.req_valid = 1'b1; bus.req_idx = idx; bus.req_key = key;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_idx = 2'($urandom); bus.req_key = $urandom; relock = rl;
    @(negedge clk);
    chk("check_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("check_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    relock = '0;
    pass = (key == KEY);
    v = eff_locked(cyc);
    if (pass) begin
      m_fail = 0; v[idx] = 1'b0; m_ucyc[idx] = cyc;
    end else begin
      m_fail = (m_fail + 1 > MAXF) ? MAXF : m_fail + 1;
      if (m_fail == MAXF) begin m_lockout = 1'b1; v = '1; end
    end
    v = v | rl;
    store(v);
    @(negedge clk);
    chk("resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("resp_ok", 32'(bus.resp_ok), 32'(pass));
    chk_all("resp");
    @(posedge clk);
    @(negedge clk);
    chk("resp_done", 32'(bus.resp_valid), 32'd0);
    chk("ready_back", 32'(bus.req_ready), 32'(!m_lockout));
    chk_all("after");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]   k;
    logic [NL-1:0] rl;
    resetn = 1'b0; relock = '0;
    bus.req_valid = 1'b0; bus.req_idx = 2'd0; bus.req_key = 32'd0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_ok", 32'(bus.resp_ok), 32'd0);
    chk_all("rst");
    resetn = 1'b1;
    repeat (5) idle('0);
    chk("idle_ready", 32'(bus.req_ready), 32'd1);
    chk("idle_locked", 32'(locked), 32'hF);

    // Basic unlock of channel 2
    do_req(2'd2, KEY, '0);
    chk("unlock2_locked", 32'(locked), 32'hB);

    // wrong, wrong, correct, wrong: failures must be consecutive
    do_req(2'd0, 32'd0, '0);
    do_req(2'd0, 32'd0, '0);
    do_req(2'd0, KEY, '0);
    do_req(2'd0, 32'd0, '0);
    chk("nonconsec_fail", 32'(fail_cnt), 32'd1);
    do_req(2'd3, KEY, '0);

    // Relock on the CHECK edge wins over the unlock; later relock pulse re-locks
    do_req(2'd1, KEY, 4'b0010);
    chk("relock_wins", 32'(locked[1]), 32'd1);
    do_req(2'd1, KEY, '0);
    idle(4'b0010);
    chk("relock_pulse", 32'(locked[1]), 32'd1);

    // Watch a fresh unlock for longer than the relock timeout
    do_req(2'd3, KEY, '0);
    repeat (12) idle('0);

    // Random requests and relock strobes, kept short of lockout
    for (int it = 0; it < 60; it++) begin
      rl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      if ($urandom_range(0, 3) == 0) begin
        idle(rl);
      end else begin
        k = (m_fail == MAXF - 1 || $urandom_range(0, 2) != 0) ? KEY : $urandom;
        do_req(2'($urandom), k, rl);
      end
    end

    // Reset asserted while a request is in CHECK discards the response
    do_req(2'd0, KEY, '0);
    do_req(2'd0, 32'd0, '0);
    bus.req_valid = 1'b1; bus.req_idx = 2'd1; bus.req_key = KEY;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    m_reset();
    chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("midrst_resp_ok", 32'(bus.resp_ok), 32'd0);
    chk("midrst_ready", 32'(bus.req_ready), 32'd0);
    chk_all("midrst");
    @(posedge clk);
    @(negedge clk);
    chk("midrst_no_resp", 32'(bus.resp_valid), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("midrst_release_rv", 32'(bus.resp_valid), 32'd0);
    chk("midrst_release_ready", 32'(bus.req_ready), 32'd1);
    chk_all("midrst_release");

    // Three consecutive wrong keys trip the permanent lockout
    do_req(2'd2, KEY, '0);
    do_req(2'd0, 32'd0, '0);
    do_req(2'd0, 32'd0, '0);
    do_req(2'd0, 32'd0, '0);
    chk("lockout_flag", 32'(lockout), 32'd1);
    chk("lockout_locked", 32'(locked), 32'hF);
    bus.req_valid = 1'b1; bus.req_idx = 2'd1; bus.req_key = KEY;
    for (int i = 0; i < 6; i++) begin
      relock = 4'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("lockout_ready", 32'(bus.req_ready), 32'd0);
      chk("lockout_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("lockout_hold_locked", 32'(locked), 32'hF);
      chk("lockout_hold_flag", 32'(lockout), 32'd1);
    end
    bus.req_valid = 1'b0; relock = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
